// File: rtl/npn4_pkg.sv
// Shared types and constants for the 4-input NPN canonicalizer.
package npn4_pkg;

    localparam int unsigned TT_W   = 16;
    localparam int unsigned N_PERM = 24;
    localparam int unsigned N_PAIR = 384;

    // Entry k holds (p(0), p(1), p(2), p(3)): input i of the result reads source input p(i).
    // Entries are in lexicographic order, so 0 is the identity and 23 is (3,2,1,0).
    localparam logic [1:0] PERM_TABLE [N_PERM][4] = '{
        '{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd0, 2'd1, 2'd3, 2'd2},
        '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd0, 2'd2, 2'd3, 2'd1},
        '{2'd0, 2'd3, 2'd1, 2'd2}, '{2'd0, 2'd3, 2'd2, 2'd1},
        '{2'd1, 2'd0, 2'd2, 2'd3}, '{2'd1, 2'd0, 2'd3, 2'd2},
        '{2'd1, 2'd2, 2'd0, 2'd3}, '{2'd1, 2'd2, 2'd3, 2'd0},
        '{2'd1, 2'd3, 2'd0, 2'd2}, '{2'd1, 2'd3, 2'd2, 2'd0},
        '{2'd2, 2'd0, 2'd1, 2'd3}, '{2'd2, 2'd0, 2'd3, 2'd1},
        '{2'd2, 2'd1, 2'd0, 2'd3}, '{2'd2, 2'd1, 2'd3, 2'd0},
        '{2'd2, 2'd3, 2'd0, 2'd1}, '{2'd2, 2'd3, 2'd1, 2'd0},
        '{2'd3, 2'd0, 2'd1, 2'd2}, '{2'd3, 2'd0, 2'd2, 2'd1},
        '{2'd3, 2'd1, 2'd0, 2'd2}, '{2'd3, 2'd1, 2'd2, 2'd0},
        '{2'd3, 2'd2, 2'd0, 2'd1}, '{2'd3, 2'd2, 2'd1, 2'd0}
    };

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    typedef struct packed {
        logic [TT_W-1:0] canon_tt;
        logic [4:0]      perm_idx;
        logic [3:0]      neg_mask;
        logic            out_neg;
    } result_t;

endpackage

// File: rtl/npn4_xform.sv
// Combinational input permutation/negation of a 4-input truth table:
// xt[m] = tt[s] where s[p(i)] = m[i] ^ neg_mask[i].
module npn4_xform
    import npn4_pkg::*;
(
    input  logic [TT_W-1:0] tt,
    input  logic [4:0]      perm_idx,
    input  logic [3:0]      neg_mask,
    output logic [TT_W-1:0] xt
);

    logic [4:0] p;
    logic [3:0] m4;
    logic [3:0] s;

    // Build each result minterm by routing its (negated) input bits to source positions.
    always_comb begin
        xt = '0;
        m4 = '0;
        s  = '0;
        p  = (perm_idx < 5'd24) ? perm_idx : 5'd0;
        for (int unsigned m = 0; m < TT_W; m++) begin
            m4 = m[3:0];
            s  = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                s[PERM_TABLE[p][i]] = m4[i] ^ neg_mask[i];
            end
            xt[m] = tt[s];
        end
    end

endmodule

// File: rtl/npn4_canon.sv
// Sequential NPN canonicalizer: scans all 24 permutations x 16 input
// negations, one per cycle, keeping the first strictly smallest result.
module npn4_canon
    import npn4_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TT_W-1:0] tt_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TT_W-1:0] canon_tt,
    output logic [4:0]      perm_idx,
    output logic [3:0]      neg_mask,
    output logic            out_neg
);

    state_t          state;
    state_t          state_next;
    logic [8:0]      idx;
    logic [TT_W-1:0] tt_q;
    result_t         best;

    logic [TT_W-1:0] t;
    logic [TT_W-1:0] t_n;
    logic [TT_W-1:0] cand;
    logic            cand_neg;
    logic            last_pair;
    logic            stop_early;
    logic            better;

    npn4_xform u_xform (
        .tt       (tt_q),
        .perm_idx (idx[8:4]),
        .neg_mask (idx[3:0]),
        .xt       (t)
    );

    assign t_n        = ~t;
    assign cand_neg   = (t_n < t);
    assign cand       = cand_neg ? t_n : t;
    assign last_pair  = (idx == 9'(N_PAIR - 1));
    assign stop_early = EARLY_EXIT && (best.canon_tt == '0);
    assign better     = (cand < best.canon_tt);

    assign canon_tt = best.canon_tt;
    assign perm_idx = best.perm_idx;
    assign neg_mask = best.neg_mask;
    assign out_neg  = best.out_neg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SEARCH;
            end
            SEARCH: begin
                if (stop_early || last_pair) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job capture, pair counter and running best; best doubles as the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q <= '0;
            idx  <= '0;
            best <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tt_q          <= tt_in;
                        idx           <= '0;
                        best.canon_tt <= '1;
                        best.perm_idx <= '0;
                        best.neg_mask <= '0;
                        best.out_neg  <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (!stop_early) begin
                        idx <= idx + 9'd1;
                        if (better) begin
                            best.canon_tt <= cand;
                            best.perm_idx <= idx[8:4];
                            best.neg_mask <= idx[3:0];
                            best.out_neg  <= cand_neg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npn4_canon.sv
// Self-checking bench for npn4_canon: directed vector table, multi-cycle
// corner sequences and a golden-model comparison on random functions.
module tb_npn4_canon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] tt_in = '0;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, oneg_a;
    logic [15:0] canon_a;
    logic [4:0]  perm_a;
    logic [3:0]  neg_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, oneg_b;
    logic [15:0] canon_b;
    logic [4:0]  perm_b;
    logic [3:0]  neg_b;

    logic        s_in_ready, s_out_valid, s_oneg;
    logic [15:0] s_canon;
    logic [4:0]  s_perm;
    logic [3:0]  s_neg;

    always #5 clk = ~clk;

    assign in_valid_a  = in_valid && !sel;
    assign in_valid_b  = in_valid && sel;
    assign out_ready_a = out_ready && !sel;
    assign out_ready_b = out_ready && sel;
    assign s_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign s_out_valid = sel ? out_valid_b : out_valid_a;
    assign s_canon     = sel ? canon_b     : canon_a;
    assign s_perm      = sel ? perm_b      : perm_a;
    assign s_neg       = sel ? neg_b       : neg_a;
    assign s_oneg      = sel ? oneg_b      : oneg_a;

    npn4_canon #(.EARLY_EXIT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .tt_in(tt_in), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .canon_tt(canon_a), .perm_idx(perm_a), .neg_mask(neg_a), .out_neg(oneg_a)
    );

    npn4_canon #(.EARLY_EXIT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .tt_in(tt_in), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .canon_tt(canon_b), .perm_idx(perm_b), .neg_mask(neg_b), .out_neg(oneg_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pt [24][4];

    typedef struct {
        logic        sel;
        logic [15:0] tt;
        logic [15:0] canon;
        int          perm;
        logic [3:0]  neg;
        logic        oneg;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference transform, written via the inverse permutation.
    function automatic logic [15:0] apply_x(input logic [15:0] tt, input int p,
                                            input logic [3:0] n, input logic o);
        logic [15:0] c;
        logic [3:0]  mm, s;
        int          inv [4];
        for (int i = 0; i < 4; i++) inv[pt[p][i]] = i;
        c = '0;
        for (int m = 0; m < 16; m++) begin
            mm = 4'(m);
            for (int j = 0; j < 4; j++) s[j] = mm[inv[j]] ^ n[inv[j]];
            c[m] = tt[s] ^ o;
        end
        return c;
    endfunction

    task automatic golden(input logic [15:0] tt, output logic [15:0] canon, output int p,
                          output logic [3:0] n, output logic o);
        logic [15:0] t, nt, cand;
        canon = 16'hFFFF; p = 0; n = '0; o = 1'b0;
        for (int pi = 0; pi < 24; pi++) begin
            for (int ni = 0; ni < 16; ni++) begin
                t    = apply_x(tt, pi, 4'(ni), 1'b0);
                nt   = ~t;
                cand = (nt < t) ? nt : t;
                if (cand < canon) begin
                    canon = cand; p = pi; n = 4'(ni); o = (nt < t);
                end
            end
        end
    endtask

    task automatic start_job(input logic [15:0] tt);
        int w = 0;
        while (!s_in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_accept", 32'(s_in_ready), 32'd1);
        in_valid = 1'b1;
        tt_in    = tt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tt_in    = ~tt;
        check("in_ready_after_accept", 32'(s_in_ready), 32'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!s_out_valid && lat < 500) begin
            @(posedge clk); #1; lat++;
        end
        if (!s_out_valid) check("out_valid_timeout", 32'(s_out_valid), 32'd1);
    endtask

    task automatic finish_job();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_take", 32'(s_out_valid), 32'd0);
        check("in_ready_after_take", 32'(s_in_ready), 32'd1);
    endtask

    task automatic run_job(input logic which, input logic [15:0] tt, output int lat,
                           output logic [15:0] c, output int p, output logic [3:0] n,
                           output logic o);
        sel = which;
        start_job(tt);
        wait_done(lat);
        c = s_canon; p = int'(s_perm); n = s_neg; o = s_oneg;
        finish_job();
    endtask

    initial begin
        int          k, lat, p, gp;
        logic [15:0] c, gc, tt, base;
        logic [3:0]  n, gn;
        logic        o, go;
        logic [15:0] bases [4];

        k = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int cc = 0; cc < 4; cc++)
                    for (int d = 0; d < 4; d++)
                        if (a != b && a != cc && a != d && b != cc && b != d && cc != d) begin
                            pt[k] = '{a, b, cc, d};
                            k++;
                        end

        vecs[0] = '{1'b0, 16'h0000, 16'h0000, 0,  4'h0, 1'b0, 2};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0000, 0,  4'h0, 1'b1, 2};
        vecs[2] = '{1'b1, 16'h0000, 16'h0000, 0,  4'h0, 1'b0, 384};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 0,  4'h0, 1'b1, 384};
        vecs[4] = '{1'b0, 16'hAAAA, 16'h00FF, 9,  4'h0, 1'b1, 384};
        vecs[5] = '{1'b0, 16'h8000, 16'h0001, 0,  4'hF, 1'b0, 384};
        vecs[6] = '{1'b0, 16'h0001, 16'h0001, 0,  4'h0, 1'b0, 384};
        vecs[7] = '{1'b0, 16'hFFFE, 16'h0001, 0,  4'h0, 1'b1, 384};
        vecs[8] = '{1'b0, 16'h8888, 16'h000F, 16, 4'hC, 1'b0, 384};
        vecs[9] = '{1'b0, 16'h7FFF, 16'h0001, 0,  4'hF, 1'b1, 384};

        // Reset values on both instances.
        #12;
        check("rst_in_ready_a", 32'(in_ready_a), 32'd1);
        check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        check("rst_canon_a", 32'(canon_a), 32'd0);
        check("rst_perm_a", 32'(perm_a), 32'd0);
        check("rst_neg_a", 32'(neg_a), 32'd0);
        check("rst_oneg_a", 32'(oneg_a), 32'd0);
        check("rst_in_ready_b", 32'(in_ready_b), 32'd1);
        check("rst_out_valid_b", 32'(out_valid_b), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table.
        for (int v = 0; v < 10; v++) begin
            run_job(vecs[v].sel, vecs[v].tt, lat, c, p, n, o);
            check($sformatf("vec%0d_canon", v), 32'(c), 32'(vecs[v].canon));
            check($sformatf("vec%0d_perm", v), 32'(p), 32'(vecs[v].perm));
            check($sformatf("vec%0d_neg", v), 32'(n), 32'(vecs[v].neg));
            check($sformatf("vec%0d_oneg", v), 32'(o), 32'(vecs[v].oneg));
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
        end
        check("aaaa_reapply", 32'(apply_x(16'hAAAA, 9, 4'h0, 1'b1)), 32'h00FF);

        // Majority-3 with the full search: latency and golden result.
        run_job(1'b1, 16'hE8E8, lat, c, p, n, o);
        golden(16'hE8E8, gc, gp, gn, go);
        check("e8e8_latency", 32'(lat), 32'd384);
        check("e8e8_canon", 32'(c), 32'(gc));
        check("e8e8_perm", 32'(p), 32'(gp));
        check("e8e8_neg", 32'(n), 32'(gn));
        check("e8e8_oneg", 32'(o), 32'(go));

        // Back-pressure: result frozen while out_ready is low.
        sel = 1'b0;
        start_job(16'hAAAA);
        wait_done(lat);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(s_out_valid), 32'd1);
            check("bp_in_ready", 32'(s_in_ready), 32'd0);
            check("bp_canon", 32'(s_canon), 32'h00FF);
            check("bp_perm", 32'(s_perm), 32'd9);
            check("bp_neg", 32'(s_neg), 32'd0);
            check("bp_oneg", 32'(s_oneg), 32'd1);
        end
        finish_job();

        // Reset during search cycle 100 aborts the job.
        sel = 1'b0;
        start_job(16'h8000);
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid_a), 32'd0);
        check("midrst_in_ready", 32'(in_ready_a), 32'd1);
        check("midrst_canon", 32'(canon_a), 32'd0);
        check("midrst_perm", 32'(perm_a), 32'd0);
        check("midrst_neg", 32'(neg_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_out_valid", 32'(out_valid_a), 32'd0);
        check("postrst_in_ready", 32'(in_ready_a), 32'd1);
        run_job(1'b0, 16'h0001, lat, c, p, n, o);
        check("postrst_canon", 32'(c), 32'h0001);
        check("postrst_latency", 32'(lat), 32'd384);

        // Random functions against the golden model.
        for (int r = 0; r < 60; r++) begin
            tt = 16'($urandom);
            run_job(1'b0, tt, lat, c, p, n, o);
            golden(tt, gc, gp, gn, go);
            check($sformatf("rand%0d_canon tt=%h", r, tt), 32'(c), 32'(gc));
            check($sformatf("rand%0d_perm tt=%h", r, tt), 32'(p), 32'(gp));
            check($sformatf("rand%0d_neg tt=%h", r, tt), 32'(n), 32'(gn));
            check($sformatf("rand%0d_oneg tt=%h", r, tt), 32'(o), 32'(go));
            check($sformatf("rand%0d_reapply tt=%h", r, tt),
                  32'(apply_x(tt, p < 24 ? p : 0, n, o)), 32'(gc));
        end

        // Members of one NPN class share a representative.
        bases = '{16'hE8E8, 16'h6996, 16'h1234, 16'h0F3C};
        for (int b = 0; b < 4; b++) begin
            base = bases[b];
            golden(base, gc, gp, gn, go);
            for (int j = 0; j < 4; j++) begin
                tt = apply_x(base, int'($urandom_range(23, 0)), 4'($urandom_range(15, 0)),
                             1'($urandom_range(1, 0)));
                run_job(1'b0, tt, lat, c, p, n, o);
                check($sformatf("class%0d_%0d_canon tt=%h", b, j, tt), 32'(c), 32'(gc));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
